// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read ports, write ports and busy-set request.
// The master side is decode/writeback; the slave side is regfile_mp.
interface regfile_mp_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 1
);
  localparam int unsigned AW = $clog2(NREG);

  logic [NUM_RD-1:0]      rd_en_i;
  logic [NUM_RD*AW-1:0]   rd_addr_i;
  logic [NUM_RD*XLEN-1:0] rd_data_o;
  logic [NUM_RD-1:0]      rd_busy_o;
  logic [NUM_WR-1:0]      wr_en_i;
  logic [NUM_WR*AW-1:0]   wr_addr_i;
  logic [NUM_WR*XLEN-1:0] wr_data_i;
  logic                   bsy_set_i;
  logic [AW-1:0]          bsy_addr_i;

  modport master (
    output rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, bsy_set_i, bsy_addr_i,
    input  rd_data_o, rd_busy_o
  );

  modport slave (
    input  rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, bsy_set_i, bsy_addr_i,
    output rd_data_o, rd_busy_o
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired-zero x0, registered reads and a busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writes and busy updates to the read ports.
module regfile_mp #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 1
) (
  input logic         clk_i,
  input logic         rst_ni,
  regfile_mp_if.slave rf
);
  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0]        regs     [NREG];
  logic [XLEN-1:0]        regs_nxt [NREG];
  logic [NREG-1:0]        busy;
  logic [NREG-1:0]        busy_nxt;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;

  // Ascending port order lets the highest-index writer win; the busy set is applied
  // after the writeback clears so a newly issued producer overrides a retiring one.
  always_comb begin
    regs_nxt = regs;
    busy_nxt = busy;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (rf.wr_en_i[w] && (rf.wr_addr_i[w*AW +: AW] != '0)) begin
        regs_nxt[rf.wr_addr_i[w*AW +: AW]] = rf.wr_data_i[w*XLEN +: XLEN];
        busy_nxt[rf.wr_addr_i[w*AW +: AW]] = 1'b0;
      end
    end
    if (rf.bsy_set_i && (rf.bsy_addr_i != '0)) begin
      busy_nxt[rf.bsy_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs    <= '{default: '0};
      busy    <= '0;
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      regs <= regs_nxt;
      busy <= busy_nxt;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
        if (rf.rd_en_i[p]) begin
`ifdef RF_BYPASS_EN
          rd_data[p*XLEN +: XLEN] <= regs_nxt[rf.rd_addr_i[p*AW +: AW]];
          rd_busy[p]              <= busy_nxt[rf.rd_addr_i[p*AW +: AW]];
`else
          rd_data[p*XLEN +: XLEN] <= regs[rf.rd_addr_i[p*AW +: AW]];
          rd_busy[p]              <= busy[rf.rd_addr_i[p*AW +: AW]];
`endif
        end
      end
    end
  end

  assign rf.rd_data_o = rd_data;
  assign rf.rd_busy_o = rd_busy;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (two read ports, two write ports) in either bypass build.
module tb_regfile_mp;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned NUM_RD = 2;
  localparam int unsigned NUM_WR = 2;
  localparam int unsigned AW     = 5;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  logic [XLEN-1:0] m_reg  [NREG];
  bit              m_busy [NREG];
  logic [XLEN-1:0] m_rd   [NUM_RD];
  bit              m_rb   [NUM_RD];

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) rf ();

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .rf    (rf)
  );

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 0;
    end
    for (int p = 0; p < NUM_RD; p++) begin
      m_rd[p] = '0;
      m_rb[p] = 0;
    end
  endtask

  task automatic idle();
    rf.rd_en_i    = '0;
    rf.rd_addr_i  = '0;
    rf.wr_en_i    = '0;
    rf.wr_addr_i  = '0;
    rf.wr_data_i  = '0;
    rf.bsy_set_i  = 1'b0;
    rf.bsy_addr_i = '0;
  endtask

  // Advance one clock; the reference model applies the architectural rules to the inputs seen at the edge.
  task automatic cycle();
    logic [XLEN-1:0] old_reg  [NREG];
    bit              old_busy [NREG];
    int              a;
    @(posedge clk);
    if (!rst_ni) begin
      model_reset();
    end else begin
      old_reg  = m_reg;
      old_busy = m_busy;
      for (int w = 0; w < NUM_WR; w++) begin
        a = int'(rf.wr_addr_i[w*AW +: AW]);
        if (rf.wr_en_i[w] && a != 0) begin
          m_reg[a]  = rf.wr_data_i[w*XLEN +: XLEN];
          m_busy[a] = 0;
        end
      end
      if (rf.bsy_set_i && rf.bsy_addr_i != 0) m_busy[int'(rf.bsy_addr_i)] = 1;
      for (int p = 0; p < NUM_RD; p++) begin
        a = int'(rf.rd_addr_i[p*AW +: AW]);
        if (rf.rd_en_i[p]) begin
`ifdef RF_BYPASS_EN
          m_rd[p] = m_reg[a];
          m_rb[p] = m_busy[a];
`else
          m_rd[p] = old_reg[a];
          m_rb[p] = old_busy[a];
`endif
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rf.wr_en_i    = 2'b11;
      rf.wr_addr_i  = AW'(($urandom_range(1, 31))) | (10'($urandom_range(1, 31)) << AW);
      rf.wr_data_i  = {$urandom, $urandom};
      rf.rd_en_i    = 2'b11;
      rf.rd_addr_i  = 10'($urandom);
      rf.bsy_set_i  = 1'b1;
      rf.bsy_addr_i = 5'($urandom_range(1, 31));
      cycle();
    end
    total_cnt++;
    if (rf.rd_data_o !== '0 || rf.rd_busy_o !== '0) begin
      $display("FAIL reset_outputs: data=%h busy=%b expected 0/0", rf.rd_data_o, rf.rd_busy_o);
    end else pass_cnt++;
    idle();
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rf.rd_en_i   = 2'b11;
      rf.rd_addr_i = 10'($urandom);
      cycle();
      total_cnt++;
      if (rf.rd_data_o !== '0 || rf.rd_busy_o !== '0) begin
        $display("FAIL reset_regs: data=%h busy=%b expected 0/0", rf.rd_data_o, rf.rd_busy_o);
      end else pass_cnt++;
    end
  endtask

  task automatic test_write_read();
    idle();
    rf.wr_en_i   = 2'b01;
    rf.wr_addr_i = 10'd5;
    rf.wr_data_i = {32'h0, 32'hDEADBEEF};
    cycle();
    idle();
    rf.rd_en_i   = 2'b01;
    rf.rd_addr_i = 10'd5;
    cycle();
    total_cnt++;
    if (rf.rd_data_o[31:0] !== 32'hDEADBEEF) begin
      $display("FAIL write_read_x5: got %h expected deadbeef", rf.rd_data_o[31:0]);
    end else pass_cnt++;
    // With rd_en low the registered output must hold even though the address moves.
    idle();
    rf.rd_addr_i = 10'd9;
    cycle();
    total_cnt++;
    if (rf.rd_data_o[31:0] !== 32'hDEADBEEF) begin
      $display("FAIL hold_output: got %h expected deadbeef", rf.rd_data_o[31:0]);
    end else pass_cnt++;
  endtask

  task automatic test_x0();
    idle();
    rf.wr_en_i    = 2'b11;
    rf.wr_addr_i  = 10'd0;
    rf.wr_data_i  = {32'h5678, 32'h1234};
    rf.bsy_set_i  = 1'b1;
    rf.bsy_addr_i = 5'd0;
    cycle();
    idle();
    rf.rd_en_i   = 2'b10;
    rf.rd_addr_i = 10'd0;
    cycle();
    total_cnt++;
    if (rf.rd_data_o[63:32] !== 32'h0 || rf.rd_busy_o[1] !== 1'b0) begin
      $display("FAIL x0_zero: data=%h busy=%b expected 0/0", rf.rd_data_o[63:32], rf.rd_busy_o[1]);
    end else pass_cnt++;
  endtask

  task automatic test_bypass();
    idle();
    rf.wr_en_i   = 2'b01;
    rf.wr_addr_i = 10'd7;
    rf.wr_data_i = {32'h0, 32'hA5A5A5A5};
    rf.rd_en_i   = 2'b01;
    rf.rd_addr_i = 10'd7;
    cycle();
    total_cnt++;
`ifdef RF_BYPASS_EN
    if (rf.rd_data_o[31:0] !== 32'hA5A5A5A5) begin
      $display("FAIL same_cycle_read: got %h expected a5a5a5a5", rf.rd_data_o[31:0]);
    end else pass_cnt++;
`else
    if (rf.rd_data_o[31:0] !== 32'h0) begin
      $display("FAIL same_cycle_read: got %h expected 00000000", rf.rd_data_o[31:0]);
    end else pass_cnt++;
`endif
    idle();
    rf.rd_en_i   = 2'b01;
    rf.rd_addr_i = 10'd7;
    cycle();
    total_cnt++;
    if (rf.rd_data_o[31:0] !== 32'hA5A5A5A5) begin
      $display("FAIL following_read: got %h expected a5a5a5a5", rf.rd_data_o[31:0]);
    end else pass_cnt++;
  endtask

  task automatic test_multi_write();
    idle();
    rf.wr_en_i   = 2'b11;
    rf.wr_addr_i = {5'd3, 5'd3};
    rf.wr_data_i = {32'h22, 32'h11};
    cycle();
    idle();
    rf.rd_en_i   = 2'b11;
    rf.rd_addr_i = {5'd3, 5'd3};
    cycle();
    total_cnt++;
    if (rf.rd_data_o !== {32'h22, 32'h22}) begin
      $display("FAIL multi_write_x3: got %h expected 22 on both ports", rf.rd_data_o);
    end else pass_cnt++;
  endtask

  task automatic test_busy();
    idle();
    rf.bsy_set_i  = 1'b1;
    rf.bsy_addr_i = 5'd9;
    cycle();
    idle();
    rf.rd_en_i   = 2'b01;
    rf.rd_addr_i = 10'd9;
    cycle();
    total_cnt++;
    if (rf.rd_busy_o[0] !== 1'b1) begin
      $display("FAIL busy_set: got %b expected 1", rf.rd_busy_o[0]);
    end else pass_cnt++;
    rf.wr_en_i    = 2'b01;
    rf.wr_addr_i  = 10'd9;
    rf.wr_data_i  = {32'h0, 32'h99};
    rf.bsy_set_i  = 1'b1;
    rf.bsy_addr_i = 5'd9;
    cycle();
    idle();
    rf.rd_en_i   = 2'b01;
    rf.rd_addr_i = 10'd9;
    cycle();
    total_cnt++;
    if (rf.rd_busy_o[0] !== 1'b1) begin
      $display("FAIL busy_set_wins: got %b expected 1", rf.rd_busy_o[0]);
    end else pass_cnt++;
    rf.wr_en_i   = 2'b10;
    rf.wr_addr_i = {5'd9, 5'd0};
    rf.wr_data_i = {32'h98, 32'h0};
    cycle();
    total_cnt++;
`ifdef RF_BYPASS_EN
    if (rf.rd_busy_o[0] !== 1'b0) begin
      $display("FAIL busy_clear_same: got %b expected 0", rf.rd_busy_o[0]);
    end else pass_cnt++;
`else
    if (rf.rd_busy_o[0] !== 1'b1) begin
      $display("FAIL busy_clear_same: got %b expected 1", rf.rd_busy_o[0]);
    end else pass_cnt++;
`endif
    idle();
    rf.rd_en_i   = 2'b01;
    rf.rd_addr_i = 10'd9;
    cycle();
    total_cnt++;
    if (rf.rd_busy_o[0] !== 1'b0 || rf.rd_data_o[31:0] !== 32'h98) begin
      $display("FAIL busy_cleared: busy=%b data=%h expected 0/98", rf.rd_busy_o[0], rf.rd_data_o[31:0]);
    end else pass_cnt++;
    rf.bsy_set_i  = 1'b1;
    rf.bsy_addr_i = 5'd9;
    cycle();
    idle();
    rf.rd_en_i   = 2'b01;
    rf.rd_addr_i = 10'd9;
    cycle();
    // Asynchronous reset between edges must clear the registered outputs immediately.
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    total_cnt++;
    if (rf.rd_busy_o !== '0 || rf.rd_data_o !== '0) begin
      $display("FAIL async_reset_busy: busy=%b data=%h expected 0/0", rf.rd_busy_o, rf.rd_data_o);
    end else pass_cnt++;
    #1 rst_ni = 1'b1;
    idle();
    rf.rd_en_i   = 2'b01;
    rf.rd_addr_i = 10'd9;
    cycle();
    total_cnt++;
    if (rf.rd_busy_o[0] !== 1'b0 || rf.rd_data_o[31:0] !== 32'h0) begin
      $display("FAIL post_reset_x9: busy=%b data=%h expected 0/0", rf.rd_busy_o[0], rf.rd_data_o[31:0]);
    end else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rf.rd_en_i    = 2'($urandom);
      rf.rd_addr_i  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rf.wr_en_i    = 2'($urandom);
      rf.wr_addr_i  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rf.wr_data_i  = {$urandom, $urandom};
      rf.bsy_set_i  = 1'($urandom);
      rf.bsy_addr_i = 5'($urandom_range(0, 7));
      cycle();
      for (int p = 0; p < NUM_RD; p++) begin
        total_cnt++;
        if (rf.rd_data_o[p*XLEN +: XLEN] !== m_rd[p] || rf.rd_busy_o[p] !== m_rb[p]) begin
          $display("FAIL random_port%0d cycle %0d: data=%h busy=%b expected %h/%b",
                   p, i, rf.rd_data_o[p*XLEN +: XLEN], rf.rd_busy_o[p], m_rd[p], m_rb[p]);
        end else pass_cnt++;
      end
    end
  endtask

  initial begin
    model_reset();
    idle();
    test_reset();
    test_write_read();
    test_x0();
    test_bypass();
    test_multi_write();
    test_busy();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
